// File: rtl/oam_dma.sv
// Sprite-memory DMA: a CPU write to TRIG_ADDR halts the core and copies one
// 256-byte page to the OAM data port as read/write pairs aligned to even cycles.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_rw,
  output logic        halt,
  output logic        dma_active,
  output logic [15:0] bus_a,
  output logic        bus_rw,
  output logic [7:0]  bus_d_out,
  input  logic [7:0]  bus_d_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  buf_q, buf_d;
  logic        p_q, p_d;

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    n_d        = n_q;
    buf_d      = buf_q;
    p_d        = ~p_q;
    halt       = 1'b1;
    dma_active = 1'b0;
    bus_a      = '0;
    bus_rw     = 1'b1;
    bus_d_out  = '0;

    unique case (state_q)
      S_IDLE: begin
        halt = 1'b0;
        if (cpu_a == TRIG_ADDR && !cpu_rw) begin
          page_d  = cpu_d;
          n_d     = '0;
          state_d = S_HALT;
        end
      end
      // The dead CPU cycle; insert ALIGN only when the next cycle would be odd.
      S_HALT:  state_d = p_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        dma_active = 1'b1;
        bus_a      = {page_q, n_q};
        buf_d      = bus_d_in;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        dma_active = 1'b1;
        bus_a      = OAM_ADDR;
        bus_rw     = 1'b0;
        bus_d_out  = buf_q;
        n_d        = n_q + 8'd1;
        state_d    = (n_q == 8'hFF) ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      n_q     <= '0;
      buf_q   <= '0;
      p_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      n_q     <= n_d;
      buf_q   <= buf_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-memory DMA engine on the 6502 CPU's external bus, between the core and the system bus/address decoder. A CPU write to $4014 with value P halts the core. The engine then copies 256 bytes from $P00–$PFF to the PPU OAM data port $2004 as read/write pairs, and releases the core when done. Total stall is 513 or 514 cycles depending on cycle parity, matching NES behaviour.

## Interface
Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts a transfer
- OAM_ADDR, 16'h2004, destination address for every write cycle

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- cpu_a  in  16  CPU address bus
- cpu_d  in  8  CPU write data
- cpu_rw  in  1  CPU direction, 1 = read, 0 = write
- halt  out  1  stalls the CPU core while high; core holds all state
- dma_active  out  1  high when engine owns the bus; selects bus_* over CPU signals in the bus mux
- bus_a  out  16  DMA address
- bus_rw  out  1  DMA direction, 1 = read, 0 = write
- bus_d_out  out  8  DMA write data
- bus_d_in  in  8  bus read data

## Operation
- State machine states: IDLE, HALT, ALIGN, READ, WRITE.
- Internal registers:
  - page (8 bits)
  - n (8-bit byte counter)
  - buf (8 bits)
  - p (parity bit, toggles every clk; reset 0)
- IDLE:
  - On a cycle with cpu_a==TRIG_ADDR and cpu_rw==0, latch page<=cpu_d and n<=0, then go to HALT.
  - Other CPU traffic is ignored.
- HALT: halt=1 and dma_active=0 (the CPU bus cycle is dead). Next state is READ if p==1 in this cycle, otherwise ALIGN.
- ALIGN: halt=1, dma_active=0, next state READ. This guarantees every READ occurs with p==0.
- READ: halt=1, dma_active=1, bus_a={page,n}, bus_rw=1. At the clock edge ending the cycle, buf<=bus_d_in; next state WRITE.
- WRITE: halt=1, dma_active=1, bus_a=OAM_ADDR, bus_rw=0, bus_d_out=buf. At the clock edge:
  - if n==8'hFF: go to IDLE (n wraps to 0);
  - else n<=n+1 and go to READ.
- Outputs are combinational decodes of state and registers:
  - halt is high in HALT/ALIGN/READ/WRITE.
  - dma_active is high in READ/WRITE.
- When dma_active==0: bus_a=16'h0000, bus_rw=1, bus_d_out=8'h00.
- bus_d_out is buf in WRITE only. It is 8'h00 otherwise.
- Boundary conditions:
  - Write to TRIG_ADDR while not IDLE: ignored. page, n and state are unchanged.
  - A CPU read of TRIG_ADDR never triggers.
  - Trigger and rst in the same cycle: rst wins, and the state is IDLE.
  - rst mid-transfer: next cycle state=IDLE, halt=0, dma_active=0, n=0, page=0, buf=0, p=0. Partial OAM contents are left as written.
  - page=8'hFF: addresses $FF00–$FFFF, with no carry into higher bits.
  - The counter wraps only at the final WRITE. Exactly 256 READ and 256 WRITE cycles per transfer.

## Timing
- Reset values: state=IDLE, halt=0, dma_active=0, bus_a=0, bus_rw=1, bus_d_out=0, p=0.
- Cycle T is the CPU write cycle to TRIG_ADDR. halt rises in T+1.
- First READ is in T+2 if p==1 during T+1, otherwise in T+3.
- READ/WRITE alternate every cycle with no gaps.
- Last WRITE ends at T+513 (no align) or T+514 (align).
- halt falls in the first cycle after the last WRITE. Stall length is 513 or 514 cycles.
- Read data is sampled on the rising edge that ends READ. Memory must drive valid data within the READ cycle.
- A new trigger is accepted in the first IDLE cycle after completion (back-to-back DMA).

## Test plan
- **Reset then trigger, even alignment:** reset, write $4014=$02 at a cycle where p==0 in T+1 → ALIGN occurs, first READ at $0200 in T+3, halt high for 514 cycles, dma_active low in HALT/ALIGN.
- **Odd alignment:** same transfer shifted one cycle → no ALIGN, first READ in T+2, halt high exactly 513 cycles.
- **Data path:** memory $0300+i = i^8'h5A, page $03 → 256 writes to $2004 with data $5A,$5B,...,$A5 in order. Every write is preceded by a read of $03ii, and no extra bus cycles occur.
- **Ignored triggers:**
  - CPU read of $4014: no halt.
  - Write to $4015: no halt.
  - Second write $4014=$07 injected mid-transfer: page stays at the original value and the cycle count is unchanged.
- **Reset mid-transfer:** assert rst at the 100th WRITE → next cycle halt=0, dma_active=0, bus_rw=1, bus_a=0. A new trigger with $05 then starts at $0500 with n=0.
- **Page wrap and back-to-back:** page $FF → last read $FFFF with no carry. Immediately re-trigger with $00 in the first IDLE cycle → second transfer starts and reads $0000.
